// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-interface arbiter.
// Optional feature macro: REG_ARB_TIMEOUT_EN (ack timeout).
package reg_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DONE
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_grant_sel.sv
// Combinational round-robin winner select.
// Search begins one past the last granted requester.
module rr_grant_sel #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [NUM_REQ-1:0]         o_gnt
);

  always_comb begin
    int   idx;
    logic found;
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(i_last) + k) % NUM_REQ;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_if_arb.sv
// Round-robin arbiter from NUM_REQ requesters onto one register port.
// Optional ack timeout enabled by defining REG_ARB_TIMEOUT_EN.
module reg_if_arb
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              s_req,
  input  logic [NUM_REQ-1:0]              s_wren,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_wstrb,
  output logic [NUM_REQ-1:0]              s_ack,
  output logic [DATA_WIDTH-1:0]           s_rdata,
  output logic                            s_err,
  output logic [ADDR_WIDTH-1:0]           reg_addr,
  output logic [DATA_WIDTH-1:0]           reg_wdata,
  output logic [DATA_WIDTH/8-1:0]         reg_wstrb,
  output logic                            reg_wren,
  output logic                            reg_rden,
  output logic                            reg_req,
  input  logic [DATA_WIDTH-1:0]           reg_rdata,
  input  logic                            reg_ack
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     w_widx;
  logic [NUM_REQ-1:0] w_gnt;
  logic              w_tmo;
  logic              w_fin;

  rr_grant_sel #(
    .NUM_REQ(NUM_REQ)
  ) u_sel (
    .i_req (s_req),
    .i_last(r_last),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_widx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt[i]) w_widx = IW'(i);
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  assign w_tmo = (r_state == S_GRANT) && !reg_ack &&
                 (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == S_GRANT) r_cnt <= r_cnt + 1'b1;
    else                        r_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        s_err <= 1'b0;
    else if (w_fin) s_err <= w_tmo;
    else            s_err <= 1'b0;
  end
`else
  assign w_tmo = 1'b0;
  assign s_err = 1'b0;
`endif

  assign w_fin = (r_state == S_GRANT) && (reg_ack || w_tmo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|s_req) w_next = S_GRANT;
      S_GRANT: if (w_fin)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last    <= IW'(NUM_REQ - 1);
      r_gidx    <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      reg_wren  <= 1'b0;
      reg_rden  <= 1'b0;
      reg_req   <= 1'b0;
      s_ack     <= '0;
      s_rdata   <= '0;
    end else begin
      s_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (|s_req) begin
            r_gidx    <= w_widx;
            r_last    <= w_widx;
            reg_addr  <= s_addr[w_widx*ADDR_WIDTH +: ADDR_WIDTH];
            reg_wdata <= s_wdata[w_widx*DATA_WIDTH +: DATA_WIDTH];
            reg_wstrb <= s_wstrb[w_widx*SW +: SW];
            reg_wren  <= s_wren[w_widx];
            reg_rden  <= !s_wren[w_widx];
            reg_req   <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_fin) begin
            reg_req       <= 1'b0;
            reg_wren      <= 1'b0;
            reg_rden      <= 1'b0;
            s_ack[r_gidx] <= 1'b1;
            if (w_tmo)         s_rdata <= DATA_WIDTH'(ERR_RDATA);
            else if (reg_wren) s_rdata <= '0;
            else               s_rdata <= reg_rdata;
          end
        end
        default: s_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_if_arb.sv
// Self-checking bench for reg_if_arb: vector table, corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_reg_if_arb;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk;
  logic              rst;
  logic [N-1:0]      s_req;
  logic [N-1:0]      s_wren;
  logic [N*AW-1:0]   s_addr;
  logic [N*DW-1:0]   s_wdata;
  logic [N*SW-1:0]   s_wstrb;
  logic [N-1:0]      s_ack;
  logic [DW-1:0]     s_rdata;
  logic              s_err;
  logic [AW-1:0]     reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic [SW-1:0]     reg_wstrb;
  logic              reg_wren;
  logic              reg_rden;
  logic              reg_req;
  logic [DW-1:0]     reg_rdata;
  logic              reg_ack;

  reg_if_arb #(
    .NUM_REQ       (N),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_req    (s_req),
    .s_wren   (s_wren),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .s_err    (s_err),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb),
    .reg_wren (reg_wren),
    .reg_rden (reg_rden),
    .reg_req  (reg_req),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    wren;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wd;
    logic [N*SW-1:0] ws;
    int              dly;
    logic [DW-1:0]   rd;
    int              g;
    logic [DW-1:0]   exp_rd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = N - 1;

  logic [N-1:0]    pend;
  logic [N-1:0]    m_wren;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wd;
  logic [N*SW-1:0] m_ws;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] wren,
                         input logic [N*AW-1:0] addr,
                         input logic [N*DW-1:0] wd,
                         input logic [N*SW-1:0] ws, input int dly,
                         input logic [DW-1:0] rd, input int g,
                         input logic [DW-1:0] exp_rd);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    s_req = req; s_wren = wren; s_addr = addr;
    s_wdata = wd; s_wstrb = ws;
    tick();
    chk("reg_req_lat", reg_req, 1);
    chk("reg_addr", reg_addr, addr[g*AW +: AW]);
    chk("reg_wren", reg_wren, wren[g]);
    chk("reg_rden", reg_rden, !wren[g]);
    chk("reg_wdata", reg_wdata, wd[g*DW +: DW]);
    chk("reg_wstrb", reg_wstrb, ws[g*SW +: SW]);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("reg_req_hold", reg_req, 1);
      chk("s_ack_early", s_ack, 0);
    end
    reg_ack = 1'b1;
    reg_rdata = rd;
    tick();
    reg_ack = 1'b0;
    reg_rdata = $urandom;
    chk("s_ack", s_ack, oh);
    chk("s_rdata", s_rdata, exp_rd);
    chk("s_err", s_err, 0);
    chk("reg_req_drop", reg_req, 0);
    s_req[g] = 1'b0;
    tick();
    chk("s_ack_pulse", s_ack, 0);
    m_last = g;
  endtask

  task automatic raise(input int i);
    pend[i] = 1'b1;
    m_wren[i] = 1'($urandom_range(0, 1));
    m_addr[i*AW +: AW] = AW'($urandom);
    m_wd[i*DW +: DW] = DW'($urandom);
    m_ws[i*SW +: SW] = SW'($urandom);
  endtask

  vec_t tbl[6];

  initial begin
    int g;
    int dly;
    logic [DW-1:0] rd;

    tbl[0] = '{req: 2'b01, wren: 2'b00, addr: {4'd0, 4'd3}, wd: '0, ws: '0,
               dly: 2, rd: 32'h1234_5678, g: 0, exp_rd: 32'h1234_5678};
    tbl[1] = '{req: 2'b10, wren: 2'b10, addr: {4'd5, 4'd0},
               wd: {32'hA5A5_A5A5, 32'h0}, ws: {4'hF, 4'h0},
               dly: 1, rd: 32'hFFFF_FFFF, g: 1, exp_rd: 32'h0};
    for (int i = 0; i < 4; i++)
      tbl[2+i] = '{req: 2'b11, wren: 2'b00, addr: {4'd2, 4'd1},
                   wd: {32'h2, 32'h1}, ws: {4'h3, 4'hC}, dly: 0,
                   rd: DW'(32'h11 * (i + 1)), g: i % 2,
                   exp_rd: DW'(32'h11 * (i + 1))};

    rst = 1'b1;
    s_req = '0; s_wren = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    reg_rdata = '0; reg_ack = 1'b0;
    tick(); tick();
    chk("rst_reg_req", reg_req, 0);
    chk("rst_reg_wren", reg_wren, 0);
    chk("rst_reg_rden", reg_rden, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_s_ack", s_ack, 0);
    chk("rst_s_rdata", s_rdata, 0);
    chk("rst_s_err", s_err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].req, tbl[i].wren, tbl[i].addr, tbl[i].wd, tbl[i].ws,
              tbl[i].dly, tbl[i].rd, tbl[i].g, tbl[i].exp_rd);

    run_txn(2'b01, 2'b00, {4'd0, 4'd9}, '0, '0, 0, 32'hCAFE, 0, 32'hCAFE);
    s_req = 2'b01; s_wren = 2'b00;
    tick();
    chk("pre_rst_req", reg_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", reg_req, 0);
    chk("rst_async_ack", s_ack, 0);
    tick(); tick();
    s_req = '0;
    rst = 1'b0;
    m_last = N - 1;
    reg_ack = 1'b1;
    tick();
    chk("stray_ack_s_ack", s_ack, 0);
    tick();
    chk("stray_ack_req", reg_req, 0);
    chk("stray_ack_s_ack2", s_ack, 0);
    reg_ack = 1'b0;
    tick();
    run_txn(2'b11, 2'b00, {4'd6, 4'd4}, '0, '0, 1, 32'hBEEF, 0, 32'hBEEF);

`ifdef REG_ARB_TIMEOUT_EN
    s_req = 2'b10; s_wren = 2'b00; s_addr = {4'd7, 4'd0};
    tick();
    chk("tmo_req_on", reg_req, 1);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("tmo_req_hold", reg_req, 1);
    tick();
    chk("tmo_req_drop", reg_req, 0);
    chk("tmo_s_ack", s_ack, 2'b10);
    chk("tmo_s_err", s_err, 1);
    chk("tmo_s_rdata", s_rdata, 32'hDEAD_BEEF);
    s_req = '0;
    tick();
    chk("tmo_ack_pulse", s_ack, 0);
    chk("tmo_err_pulse", s_err, 0);
    m_last = 1;
`endif

    pend = '0; m_wren = '0; m_addr = '0; m_wd = '0; m_ws = '0;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) raise(i);
      if (pend == '0) raise(int'($urandom_range(0, N - 1)));
      g = rr_pick(pend, m_last);
      dly = int'($urandom_range(0, 4));
      rd = DW'($urandom);
      run_txn(pend, m_wren, m_addr, m_wd, m_ws, dly, rd, g,
              m_wren[g] ? '0 : rd);
      pend[g] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_if_arb.md
REG_IF_ARB -- requirements
Module: reg_if_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register data width (multiple of 8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, ack wait limit (used only with REG_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_req  in  NUM_REQ  per-requester request level.
REQ-008 SHALL have port s_wren  in  NUM_REQ  per-requester write (1) / read (0) select.
REQ-009 SHALL have port s_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
REQ-010 SHALL have port s_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-011 SHALL have port s_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
REQ-012 SHALL have port s_ack  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-013 SHALL have port s_rdata  out  DATA_WIDTH  read data, shared, valid with s_ack.
REQ-014 SHALL have port s_err  out  1  timeout flag, valid with s_ack.
REQ-015 SHALL have ports reg_addr/reg_wdata/reg_wstrb  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  downstream register access fields.
REQ-016 SHALL have ports reg_wren, reg_rden, reg_req  out  1 each  downstream strobes.
REQ-017 SHALL have ports reg_rdata  in  DATA_WIDTH and reg_ack  in  1  downstream response.

Function
REQ-018 SHALL implement FSM IDLE -> GRANT -> DONE -> IDLE.
REQ-019 IDLE: if any s_req high, SHALL latch the round-robin winner's fields into registered reg_* outputs and enter GRANT next cycle.
REQ-020 Round-robin: search SHALL start at last_grant+1 modulo NUM_REQ; last_grant resets to NUM_REQ-1 (requester 0 wins first).
REQ-021 GRANT: reg_req SHALL be held high with fields stable; reg_wren = latched wren, reg_rden = ~latched wren.
REQ-022 On reg_ack high in GRANT, SHALL capture reg_rdata, deassert reg_req/reg_wren/reg_rden, enter DONE.
REQ-023 DONE: s_ack[grant] SHALL be high exactly one cycle with s_rdata (reads; 0 for writes) and s_err; then IDLE.
REQ-024 Latency: s_req sampled high in IDLE at cycle N -> reg_req high at N+1; reg_ack at cycle M -> s_ack at M+1.
REQ-025 Requester SHALL hold s_req and fields until s_ack, drop s_req the cycle after; arbiter ignores changes to non-granted requests while busy.
REQ-026 reg_ack outside GRANT SHALL be ignored.
REQ-027 Simultaneous requests SHALL be served one at a time in round-robin order; no requester starves beyond NUM_REQ-1 transactions.

Reset
REQ-028 rst high SHALL asynchronously force IDLE, all outputs 0, last_grant = NUM_REQ-1, timeout counter 0, aborting any transaction in flight without s_ack.

Configuration
REQ-029 With REG_ARB_TIMEOUT_EN defined: counter runs in GRANT; at TIMEOUT_CYCLES cycles without reg_ack SHALL drop reg_req and enter DONE with s_err=1, s_rdata=32'hDEAD_BEEF (DATA_WIDTH-truncated).
REQ-030 Without REG_ARB_TIMEOUT_EN: no counter; GRANT waits indefinitely; s_err tied 0.

Structure
REQ-031 Package reg_arb_pkg SHALL hold the FSM state enum and the ERR_RDATA constant.
REQ-032 Sub-module rr_grant_sel SHALL compute the combinational one-hot winner from requests and last_grant.

Verification
REQ-033 Single read: s_req[0], addr 3; reg_ack 2 cycles after reg_req with rdata 0x12345678 -> reg_rden=1, reg_addr=3, s_ack[0] pulse, s_rdata=0x12345678.
REQ-034 Single write: s_req[1], addr 5, wdata 0xA5A5A5A5, wstrb 0xF -> reg_wren=1 with those fields, s_ack[1] pulse, s_rdata=0.
REQ-035 Contention: s_req=2'b11 held, ack immediately -> grant order 0,1,0,1 over four transactions.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16): reg_ack never asserted -> reg_req drops after 16 cycles, s_ack with s_err=1, s_rdata=0xDEADBEEF.
REQ-037 Reset mid-GRANT: rst pulsed while reg_req high -> reg_req=0 immediately, no s_ack; next request served by requester 0 first.
